shift_exec: RTL



---
 rtl/shift_exec_if.sv | 27 ++
 rtl/shift_exec.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/shift_exec_if.sv
// Issue/writeback handshake bundle for the shift execute stage.
// master drives operations and accepts results; slave is the stage.
interface shift_exec_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        out_z;
    logic        out_n;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_data, in_amt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_z, out_n, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_amt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_z, out_n, out_err
    );
endinterface

// File: rtl/shift_exec.sv
// Registered SLL/SRA execute stage around one shared 16-bit shifter.
// Define ROR_EN to add the two-pass rotate (op 10) via PASS2 state.
module shift_exec (
    input  logic         clk,
    input  logic         rst_n,
    shift_exec_if.slave  bus
);
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic [3:0]  r_out_tag;
    logic        r_out_z;
    logic        r_out_n;
    logic        r_out_err;

`ifdef ROR_EN
    typedef enum logic {IDLE, PASS2} state_t;
    state_t      r_state;
    logic [15:0] r_data;
    logic [15:0] r_part;
    logic [3:0]  r_amt;
    logic [3:0]  r_tag;
    logic        w_go_p2;
`endif

    logic        w_out_free;
    logic        w_in_ready;
    logic        w_accept;
    logic [15:0] w_sh_in;
    logic [3:0]  w_sh_amt;
    logic        w_sh_left;
    logic [15:0] w_sh_out;
    logic        w_ld;
    logic [15:0] w_ld_data;
    logic [3:0]  w_ld_tag;
    logic        w_ld_err;

    assign w_out_free = !r_out_valid | bus.out_ready;
`ifdef ROR_EN
    assign w_in_ready = rst_n & (r_state == IDLE) & w_out_free;
`else
    assign w_in_ready = rst_n & w_out_free;
`endif
    assign w_accept = bus.in_valid & w_in_ready;

    // The one shifter: left logical or right arithmetic
    assign w_sh_out = w_sh_left ? (w_sh_in << w_sh_amt)
                                : 16'($signed(w_sh_in) >>> w_sh_amt);

    always_comb begin
        w_sh_in   = bus.in_data;
        w_sh_amt  = bus.in_amt;
        w_sh_left = 1'b1;
`ifdef ROR_EN
        if (r_state == PASS2) begin
            w_sh_in   = r_data;
            w_sh_amt  = r_amt;
            w_sh_left = 1'b0;
        end else
`endif
        if (bus.in_op == 2'b01) begin
            w_sh_left = 1'b0;
        end else if (bus.in_op == 2'b10) begin
            w_sh_amt = 4'd0 - bus.in_amt;
        end
    end

    always_comb begin
        w_ld      = 1'b0;
        w_ld_data = w_sh_out;
        w_ld_tag  = bus.in_tag;
        w_ld_err  = 1'b0;
`ifdef ROR_EN
        w_go_p2   = 1'b0;
        if (r_state == PASS2) begin
            // Arithmetic shift with sign bits masked off == logical shift
            w_ld      = w_out_free;
            w_ld_data = (w_sh_out & (16'hFFFF >> r_amt)) | r_part;
            w_ld_tag  = r_tag;
        end else
`endif
        if (w_accept) begin
            unique case (bus.in_op)
                2'b00: w_ld = 1'b1;
                2'b01: w_ld = 1'b1;
`ifdef ROR_EN
                2'b10: w_go_p2 = 1'b1;
`endif
                default: begin
                    w_ld      = 1'b1;
                    w_ld_data = bus.in_data;
                    w_ld_err  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_z     <= 1'b0;
            r_out_n     <= 1'b0;
            r_out_err   <= 1'b0;
`ifdef ROR_EN
            r_state     <= IDLE;
            r_data      <= '0;
            r_part      <= '0;
            r_amt       <= '0;
            r_tag       <= '0;
`endif
        end else begin
            if (w_ld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ld_data;
                r_out_tag   <= w_ld_tag;
                r_out_z     <= (w_ld_data == 16'd0);
                r_out_n     <= w_ld_data[15];
                r_out_err   <= w_ld_err;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
`ifdef ROR_EN
            if (w_accept) begin
                r_data <= bus.in_data;
                r_amt  <= bus.in_amt;
                r_tag  <= bus.in_tag;
            end
            if (w_go_p2) begin
                r_part  <= (bus.in_amt == 4'd0) ? 16'd0 : w_sh_out;
                r_state <= PASS2;
            end else if (r_state == PASS2 && w_out_free) begin
                r_state <= IDLE;
            end
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_z     = r_out_z;
    assign bus.out_n     = r_out_n;
    assign bus.out_err   = r_out_err;
endmodule
